// File: rtl/input_debounce_sync_pkg.sv
// Shared defaults for the switch/button conditioning stage.
// The display top level and the bench override these as needed.
package input_debounce_sync_pkg;

    localparam int unsigned DEF_WIDTH           = 8;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEF_CNT_W           = 16;

endpackage : input_debounce_sync_pkg

// File: rtl/input_debounce_sync_if.sv
// Raw switch inputs in, clean debounced bus plus status flags out.
// master = debouncer side, slave = switch source / encoder side.
interface input_debounce_sync_if
    import input_debounce_sync_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] data_out;
    logic             changed;
    logic             settled;

    modport master (
        input  raw_in,
        output data_out,
        output changed,
        output settled
    );

    modport slave (
        output raw_in,
        input  data_out,
        input  changed,
        input  settled
    );

endinterface : input_debounce_sync_if

// File: rtl/input_debounce_sync_debounce_bit.sv
// One input bit: 2-flop synchronizer, stability counter and accepted-value flop.
// flip_c is high in the cycle whose rising edge updates stable_o.
module input_debounce_sync_debounce_bit
    import input_debounce_sync_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o,
    output logic flip_c
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any sample equal to the accepted value restarts the window
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        flip_c   = 1'b0;
        if (s2_q != stable_q) begin
            if (cnt_q == LAST_CNT) begin
                stable_d = s2_q;
                flip_c   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= raw_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule : input_debounce_sync_debounce_bit

// File: rtl/input_debounce_sync.sv
// Synchronizes and debounces WIDTH raw switch inputs into a clean data bus,
// with a one-cycle change strobe and a post-reset settled flag.
module input_debounce_sync
    import input_debounce_sync_pkg::*;
#(
    parameter int unsigned WIDTH           = DEF_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input logic                 clk,
    input logic                 rst,
    input_debounce_sync_if.master bus
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] flip;
    logic             changed_q;
    logic             changed_d;
    logic             settled_q;
    logic             settled_d;
    logic [CNT_W-1:0] settle_cnt_q;
    logic [CNT_W-1:0] settle_cnt_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        input_debounce_sync_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .raw_i    (bus.raw_in[i]),
            .stable_o (stable[i]),
            .flip_c   (flip[i])
        );
    end

    // Change strobe aligns with the data update; settle counter saturates
    always_comb begin
        changed_d    = |flip;
        settled_d    = settled_q;
        settle_cnt_d = settle_cnt_q;
        if (!settled_q) begin
            if (settle_cnt_q == SETTLE_LAST) begin
                settled_d = 1'b1;
            end else begin
                settle_cnt_d = settle_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            changed_q    <= 1'b0;
            settled_q    <= 1'b0;
            settle_cnt_q <= '0;
        end else begin
            changed_q    <= changed_d;
            settled_q    <= settled_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign bus.data_out = stable;
    assign bus.changed  = changed_q;
    assign bus.settled  = settled_q;

endmodule : input_debounce_sync

// File: tb/tb_input_debounce_sync.sv
// Bench for input_debounce_sync with a short debounce window; the reference
// model accepts a bit once the last DC synchronized samples all disagree.
module tb_input_debounce_sync;

    localparam int unsigned W  = 8;
    localparam int unsigned DC = 4;
    localparam int unsigned CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    input_debounce_sync_if #(.WIDTH(W)) bus ();

    input_debounce_sync #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [W-1:0] hist[$];
    logic [W-1:0] m_stable;
    logic         m_changed;
    int           m_since;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Raw samples taken before/at reset count as zero
    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < int'(DC) + 1; k++) hist.push_back('0);
        m_stable  = '0;
        m_changed = 1'b0;
        m_since   = 0;
    endtask

    // Bit accepts at edge n when samples n-DC-1 .. n-2 all differ from it
    task automatic model_edge(input logic [W-1:0] v);
        logic [W-1:0] flp;
        bit           all_diff;
        flp = '0;
        hist.push_back(v);
        for (int i = 0; i < int'(W); i++) begin
            all_diff = 1'b1;
            for (int k = 0; k < int'(DC); k++)
                if (hist[hist.size() - 3 - k][i] == m_stable[i]) all_diff = 1'b0;
            flp[i] = all_diff;
        end
        m_stable  = m_stable ^ flp;
        m_changed = |flp;
        if (m_since < int'(DC)) m_since++;
        if (hist.size() > 16) void'(hist.pop_front());
    endtask

    task automatic step(input logic [W-1:0] v);
        bus.raw_in = v;
        @(posedge clk);
        model_edge(v);
        #1;
        chk("data_out", bus.data_out, m_stable);
        chk("changed", 8'(bus.changed), 8'(m_changed));
        chk("settled", 8'(bus.settled), 8'(m_since >= int'(DC)));
    endtask

    // Assert reset away from the edge, hold one edge, release mid-cycle
    task automatic do_reset(input logic [W-1:0] v);
        #2;
        rst        = 1'b1;
        bus.raw_in = v;
        model_reset();
        #1;
        chk("rst_data", bus.data_out, 8'h00);
        chk("rst_settled", 8'(bus.settled), 8'h00);
        chk("rst_changed", 8'(bus.changed), 8'h00);
        @(posedge clk);
        #4;
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] r;

        // 1: reset and quiet release
        bus.raw_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("t1_rst_data", bus.data_out, 8'h00);
        chk("t1_rst_settled", 8'(bus.settled), 8'h00);
        chk("t1_rst_changed", 8'(bus.changed), 8'h00);
        rst = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            step(8'h00);
            chk("t1_settled", 8'(bus.settled), (j >= 4) ? 8'h01 : 8'h00);
            chk("t1_changed", 8'(bus.changed), 8'h00);
        end

        // 2: single bit rises, accepted at E+5 with one strobe
        for (int j = 0; j <= 7; j++) begin
            step(8'h80);
            chk("t2_data", bus.data_out, (j >= 5) ? 8'h80 : 8'h00);
            chk("t2_changed", 8'(bus.changed), (j == 5) ? 8'h01 : 8'h00);
        end
        for (int j = 0; j < 8; j++) step(8'h00);

        // 3: short bounce is rejected
        for (int j = 0; j < 11; j++) begin
            step((j < 3) ? 8'h08 : 8'h00);
            chk("t3_data", bus.data_out, 8'h00);
            chk("t3_changed", 8'(bus.changed), 8'h00);
        end

        // 4: toggling restarts the window; final edge is j=0
        step(8'h04); step(8'h04); step(8'h00); step(8'h00);
        for (int j = 0; j <= 6; j++) begin
            step(8'h04);
            chk("t4_data", bus.data_out, (j >= 5) ? 8'h04 : 8'h00);
        end
        for (int j = 0; j < 8; j++) step(8'h00);
        chk("t4_back", bus.data_out, 8'h00);

        // 5: three bits together, single strobe
        for (int j = 0; j <= 7; j++) begin
            step(8'h25);
            chk("t5_data", bus.data_out, (j >= 5) ? 8'h25 : 8'h00);
            chk("t5_changed", 8'(bus.changed), (j == 5) ? 8'h01 : 8'h00);
        end

        // 6: all high, then reset while inputs drop to 0x10
        for (int j = 0; j < 8; j++) step(8'hFF);
        chk("t6_pre", bus.data_out, 8'hFF);
        do_reset(8'h10);
        for (int j = 1; j <= 8; j++) begin
            step(8'h10);
            chk("t6_data", bus.data_out, (j >= 6) ? 8'h10 : 8'h00);
            chk("t6_changed", 8'(bus.changed), (j == 6) ? 8'h01 : 8'h00);
            chk("t6_settled", 8'(bus.settled), (j >= 4) ? 8'h01 : 8'h00);
        end

        // Random sparse toggling against the window model
        r = 8'h10;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) r = r ^ W'($urandom & $urandom);
            if (n == 200) do_reset(r);
            step(r);
        end
        for (int n = 0; n < 8; n++) step(r);
        chk("final_data", bus.data_out, r);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_input_debounce_sync
